// File: rtl/dmem_pkg.sv
// Shared encodings for the CPU-side data-memory request/ack initiator.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_LO   = 4'b0011;

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering: byte enables and replicated store data on the way out,
// extracted and extended load data on the way back, plus the alignment check.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    input  logic [31:0] readdata,
    output logic [3:0]  byteen,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] byte_shifted;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane k sits at bits 31-8k; shifting right by 8*(3-k) brings it to the bottom.
    assign byte_shifted = readdata >> {~offset, 3'b000};
    assign byte_lane    = byte_shifted[7:0];
    assign half_lane    = offset[1] ? readdata[15:0] : readdata[31:16];

    always_comb begin
        byteen     = BE_WORD;
        wdata_rep  = wdata;
        load_data  = readdata;
        misaligned = 1'b0;
        case (size_e'(size))
            SZ_BYTE: begin
                byteen    = 4'b1000 >> offset;
                wdata_rep = {4{wdata[7:0]}};
                load_data = is_signed ? {{24{byte_lane[7]}}, byte_lane}
                                      : {24'h000000, byte_lane};
            end
            SZ_HALF: begin
                misaligned = offset[0];
                byteen     = offset[1] ? BE_LO : BE_HI;
                wdata_rep  = {2{wdata[15:0]}};
                load_data  = is_signed ? {{16{half_lane[15]}}, half_lane}
                                       : {16'h0000, half_lane};
            end
            default: begin
                misaligned = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/dmem_initiator.sv
// MEM-stage initiator: captures one load/store, holds the bus request until ack or
// timeout, then pulses done with formatted load data while stalling the pipeline.
module dmem_initiator
    import dmem_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        buserr,
    output logic        memwrite,
    output logic        memread,
    output logic [31:0] dataadr,
    output logic [31:0] writedata,
    output logic [3:0]  byteen,
    input  logic [31:0] readdata,
    input  logic        dataack
);

    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        memwrite_d, memread_d, done_d, misalign_d, buserr_d;
    logic [31:0] dataadr_d, writedata_d, rdata_d;
    logic [3:0]  byteen_d;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_load;
    logic        lane_mis;

    dmem_lane_align u_align (
        .size      (req_size),
        .offset    (req_adr[1:0]),
        .is_signed (req_signed),
        .wdata     (req_wdata),
        .readdata  (readdata),
        .byteen    (lane_be),
        .wdata_rep (lane_wdata),
        .load_data (lane_load),
        .misaligned(lane_mis)
    );

    assign stall = req_valid & ~done;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        memwrite_d  = memwrite;
        memread_d   = memread;
        dataadr_d   = dataadr;
        writedata_d = writedata;
        byteen_d    = byteen;
        done_d      = 1'b0;
        rdata_d     = '0;
        misalign_d  = 1'b0;
        buserr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // The done cycle still sees req_valid high; ignoring it avoids a reissue.
                if (req_valid && !done) begin
                    if (lane_mis) begin
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else begin
                        dataadr_d   = {req_adr[31:2], 2'b00};
                        writedata_d = lane_wdata;
                        byteen_d    = lane_be;
                        memwrite_d  = req_write;
                        memread_d   = ~req_write;
                        cnt_d       = '0;
                        state_d     = BUSY;
                    end
                end
            end
            BUSY: begin
                if (dataack) begin
                    memwrite_d = 1'b0;
                    memread_d  = 1'b0;
                    byteen_d   = '0;
                    done_d     = 1'b1;
                    rdata_d    = memread ? lane_load : '0;
                    state_d    = IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    memwrite_d = 1'b0;
                    memread_d  = 1'b0;
                    byteen_d   = '0;
                    done_d     = 1'b1;
                    buserr_d   = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            memwrite  <= 1'b0;
            memread   <= 1'b0;
            dataadr   <= '0;
            writedata <= '0;
            byteen    <= '0;
            done      <= 1'b0;
            rdata     <= '0;
            misalign  <= 1'b0;
            buserr    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            memwrite  <= memwrite_d;
            memread   <= memread_d;
            dataadr   <= dataadr_d;
            writedata <= writedata_d;
            byteen    <= byteen_d;
            done      <= done_d;
            rdata     <= rdata_d;
            misalign  <= misalign_d;
            buserr    <= buserr_d;
        end
    end

endmodule

// File: tb/tb_dmem_initiator.sv
// Directed bench for dmem_initiator: transaction-level model of lanes and timing,
// checked every cycle, plus literal expectations for the hand-worked accesses.
module tb_dmem_initiator;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_adr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall, done, misalign, buserr, memwrite, memread;
    logic [31:0] rdata, dataadr, writedata;
    logic [3:0]  byteen;
    logic [31:0] readdata = '0;
    logic        dataack = 1'b0;

    dmem_initiator #(.ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_adr(req_adr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .rdata(rdata), .misalign(misalign), .buserr(buserr),
        .memwrite(memwrite), .memread(memread), .dataadr(dataadr),
        .writedata(writedata), .byteen(byteen),
        .readdata(readdata), .dataack(dataack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model expectations for the access in flight.
    int          exp_lo = 1, exp_hi = 0, exp_done_cyc = -1;
    logic        exp_wr = 1'b0, exp_mis = 1'b0, exp_berr = 1'b0;
    logic [3:0]  exp_be = '0;
    logic [31:0] exp_adr = '0, exp_wd = '0, exp_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] adr);
        int k;
        k = int'(adr & 32'd3);
        if (sz == 2'd0) return 4'(1 << (3 - k));
        if (sz == 2'd1) return (k == 0) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] model_ld(input logic [1:0] sz, input logic sg,
                                             input logic [31:0] adr, input logic [31:0] rd);
        int k;
        logic [31:0] v;
        k = int'(adr & 32'd3);
        if (sz == 2'd0) begin
            v = (rd >> (8 * (3 - k))) & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (rd >> (16 * (1 - k / 2))) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] adr);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return (adr % 2) != 0;
        return (adr % 4) != 0;
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic inb, dexp;
        if (reset) begin
            chk("rst_memwrite", 32'(memwrite), 32'd0);
            chk("rst_memread", 32'(memread), 32'd0);
            chk("rst_byteen", 32'(byteen), 32'd0);
            chk("rst_dataadr", dataadr, 32'd0);
            chk("rst_writedata", writedata, 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_flags", 32'({misalign, buserr}), 32'd0);
            chk("rst_stall", 32'(stall), 32'(req_valid));
        end else begin
            inb  = (cyc >= exp_lo) && (cyc <= exp_hi);
            dexp = (cyc == exp_done_cyc);
            chk("done", 32'(done), 32'(dexp));
            chk("stall", 32'(stall), 32'(req_valid && !dexp));
            chk("memwrite", 32'(memwrite), 32'(inb && exp_wr));
            chk("memread", 32'(memread), 32'(inb && !exp_wr));
            chk("byteen", 32'(byteen), inb ? 32'(exp_be) : 32'd0);
            if (inb) begin
                chk("dataadr", dataadr, exp_adr);
                chk("writedata", writedata, exp_wd);
            end
            if (dexp) begin
                chk("rdata", rdata, exp_rdata);
                chk("misalign", 32'(misalign), 32'(exp_mis));
                chk("buserr", 32'(buserr), 32'(exp_berr));
            end else begin
                chk("idle_flags", 32'({misalign, buserr}), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ack_after: bus cycle (1-based) in which dataack is driven; 0 = never ack.
    task automatic access(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] adr, input logic [31:0] wd, input logic [31:0] rd,
                          input int ack_after, input logic [3:0] lit_be,
                          input logic [31:0] lit_wd, input logic [31:0] lit_rdata);
        int  n;
        logic mis;
        n = cyc;
        mis = model_mis(sz, adr);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_adr = adr; req_wdata = wd; readdata = rd;
        exp_wr = wr; exp_be = model_be(sz, adr); exp_wd = model_wd(sz, wd);
        exp_adr = adr & 32'hFFFFFFFC; exp_mis = mis; exp_berr = 1'b0;
        exp_rdata = (wr || mis || ack_after == 0) ? 32'd0 : model_ld(sz, sg, adr, rd);
        exp_lo = n + 1;
        if (mis) begin
            exp_hi = n; exp_done_cyc = n + 1;
        end else if (ack_after == 0) begin
            exp_hi = n + TMO; exp_done_cyc = n + TMO + 1; exp_berr = 1'b1;
        end else begin
            exp_hi = n + ack_after; exp_done_cyc = n + ack_after + 1;
        end
        for (int c = n + 1; c <= exp_done_cyc; c++) begin
            tick();
            dataack = (ack_after != 0) && !mis && (cyc == n + ack_after);
            @(negedge clk);
            if (cyc == n + 1 && !mis) begin
                chk("lit_byteen", 32'(byteen), 32'(lit_be));
                chk("lit_writedata", writedata, lit_wd);
            end
            if (cyc == exp_done_cyc) chk("lit_rdata", rdata, lit_rdata);
        end
        tick();
        req_valid = 1'b0;
        dataack = 1'b0;
    endtask

    initial begin
        int n;
        tick(); tick();
        reset = 1'b0;
        tick();

        // SW 0xDEADBEEF to 0x10, memwrite held 3 cycles
        access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 3, 4'b1111, 32'hDEADBEEF, 32'h0);
        tick();
        // LB / LBU from 0x13
        access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h11223380, 1, 4'b0001, 32'h0, 32'hFFFFFF80);
        access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h11223380, 2, 4'b0001, 32'h0, 32'h00000080);
        // SH to 0x22 then LH from 0x20
        access(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000ABCD, 32'h0, 2, 4'b0011, 32'hABCDABCD, 32'h0);
        access(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 32'h8001ABCD, 1, 4'b1100, 32'h0, 32'hFFFF8001);
        // LHU upper-address half, SB middle lane, LW, reserved size as word
        access(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'h1234F00D, 3, 4'b0011, 32'h0, 32'h0000F00D);
        access(1'b1, 2'd0, 1'b0, 32'h11, 32'h1234565A, 32'h0, 1, 4'b0100, 32'h5A5A5A5A, 32'h0);
        access(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'hCAFEF00D, 2, 4'b1111, 32'h0, 32'hCAFEF00D);
        access(1'b0, 2'd3, 1'b1, 32'hC, 32'h0, 32'h0BADC0DE, 1, 4'b1111, 32'h0, 32'h0BADC0DE);
        // Misaligned LW and SH
        access(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 32'h12345678, 1, 4'b0000, 32'h0, 32'h0);
        access(1'b1, 2'd1, 1'b0, 32'h31, 32'h0000BEEF, 32'h0, 1, 4'b0000, 32'h0, 32'h0);
        // Timeout on a load; late ack two cycles later is ignored
        access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'hFFFFFFFF, 0, 4'b1111, 32'h0, 32'h0);
        tick();
        dataack = 1'b1;
        tick();
        dataack = 1'b0;
        tick(); tick();

        // Reset during the 2nd BUSY cycle of a load
        n = cyc;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_adr = 32'h44; req_wdata = '0;
        exp_wr = 1'b0; exp_be = 4'b1111; exp_wd = '0; exp_adr = 32'h44;
        exp_lo = n + 1; exp_hi = n + 100; exp_done_cyc = -1;
        tick(); tick();
        exp_hi = n + 1;
        reset = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("async_memread", 32'(memread), 32'd0);
        chk("async_byteen", 32'(byteen), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h600DF00D, 1, 4'b1111, 32'h0, 32'h600DF00D);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
